// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic        req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  stall, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output stall, rsp_valid, rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised storage behind an IDLE/WAIT/RESP
// handshake with a programmable number of wait states.
// Optional feature: define DMEM_BYTE_LANES_EN to honour req_size (byte lanes).
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic        we;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];

    req_t          in_c;
    req_t          act_c;
    logic [AW-1:0] idx_c;
    logic [1:0]    lane_c;
    logic          byte_c;
    logic [31:0]   rd_word_c;
    logic [31:0]   load_data_c;
    logic [31:0]   store_word_c;
    logic          mem_we_c;
    logic          unused_c;

    // In IDLE the incoming request is the one being looked at (needed when
    // WAIT_CYCLES=0 reads on the acceptance edge); otherwise the latched one.
    assign in_c   = {bus.req_we, bus.req_size, bus.req_addr, bus.req_wdata};
    assign act_c  = (state_q == IDLE) ? in_c : req_q;
    assign idx_c  = act_c.addr[AW+1:2];
    assign lane_c = act_c.addr[1:0];
`ifdef DMEM_BYTE_LANES_EN
    assign byte_c = act_c.size;
`else
    assign byte_c = 1'b0;
`endif
    assign unused_c  = ^{act_c.addr[31:AW+2], act_c.size};
    assign rd_word_c = mem_q[idx_c];

    // Lane extraction for loads and read-modify-write merge for stores.
    always_comb begin
        load_data_c  = rd_word_c;
        store_word_c = act_c.wdata;
        if (byte_c) begin
            load_data_c                           = {24'b0, rd_word_c[{lane_c, 3'b000} +: 8]};
            store_word_c                          = rd_word_c;
            store_word_c[{lane_c, 3'b000} +: 8]   = act_c.wdata[7:0];
        end
    end

    // Next-state, wait counter, latched request, response and stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        mem_we_c    = 1'b0;
        bus.stall   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.stall = bus.req_valid;
                if (bus.req_valid) begin
                    req_d = in_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        if (!in_c.we) rdata_d = load_data_c;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                bus.stall = 1'b1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    if (!req_q.we) rdata_d = load_data_c;
                end
            end
            RESP: begin
                mem_we_c = req_q.we;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage commit on the RESP edge; an access abandoned by reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we_c && reset) mem_q[idx_c] <= store_word_c;
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words in storage (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states inserted between acceptance and response (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port req_valid, input, 1 bit: the pipeline memory stage presents an access.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 1 bit: 0 = word, 1 = byte.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address (the ALU result of the memory stage).
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port stall, output, 1 bit: holds the pipeline while an access is outstanding.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, 32 bits: load result.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-014 SHALL, in IDLE with req_valid=1, accept the request and latch req_we, req_size, req_addr and req_wdata.
REQ-015 SHALL, on acceptance, go to WAIT with the wait counter loaded to WAIT_CYCLES, or go directly to RESP when WAIT_CYCLES=0.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP in the cycle after the counter reads 1.
REQ-017 SHALL, in RESP, drive rsp_valid=1 for exactly one cycle and return to IDLE unconditionally; a new request SHALL NOT be accepted in the RESP cycle.
REQ-018 SHALL place the rsp_valid pulse WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-019 SHALL drive stall = (state==IDLE & req_valid) | (state==WAIT), combinationally; stall SHALL be 0 in RESP.
REQ-020 SHALL form the word index from latched addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-021 SHALL, for a word access, ignore addr[1:0].
REQ-022 SHALL commit a store to the array on the RESP-cycle edge only; rdata SHALL remain unchanged on stores.
REQ-023 SHALL register load data into rdata on the edge entering RESP, so it is valid while rsp_valid=1, and SHALL hold rdata until the next load completes.
REQ-024 SHALL ignore input changes while in WAIT or RESP, since the latched request is authoritative.
REQ-025 SHALL complete back-to-back requests (req_valid held high) as successive accesses with one IDLE cycle between RESP and the next acceptance.

Reset
REQ-026 SHALL, when reset=0 at a clock edge, force state IDLE, the counter to 0, rsp_valid=0 and rdata=0.
REQ-027 SHALL, on reset mid-access (WAIT or RESP), abandon the access; a pending store SHALL NOT be written.
REQ-028 SHALL NOT clear the storage array on reset; its contents are undefined until written.

Configuration
REQ-029 SHALL, with macro DMEM_BYTE_LANES_EN defined, honour req_size=1: a byte store SHALL write only lane addr[1:0] (little-endian) with req_wdata[7:0], and a byte load SHALL return that lane zero-extended to 32 bits.
REQ-030 SHALL, without DMEM_BYTE_LANES_EN, ignore req_size and treat every access as a word access.

Verification
REQ-031 SHALL be verified with: WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 -> stall high for 3 cycles, rsp_valid on cycle 3, then a load from 0x10 returns 0xDEADBEEF.
REQ-032 SHALL be verified with: WAIT_CYCLES=0, load accepted at cycle 0 -> rsp_valid at cycle 1, stall high for exactly one cycle.
REQ-033 SHALL be verified with: store 0x11223344 to 0x04, then a load from 0x104 with DEPTH=64 -> rdata=0x11223344 (wrap-around).
REQ-034 SHALL be verified with: DMEM_BYTE_LANES_EN defined, word 0x11223344 at 0x20, byte store 0xAA to 0x22 -> word load returns 0x11AA3344, byte load of 0x23 returns 0x00000011; with the macro undefined, the same byte store -> word load returns 0x000000AA.
REQ-035 SHALL be verified with: reset=0 asserted in WAIT of a store of 0x5 to 0x8 over existing 0x7 -> next cycle state IDLE, rsp_valid=0, rdata=0, and a later load from 0x8 returns 0x7.
REQ-036 SHALL be verified with: req_valid held high for three loads -> three rsp_valid pulses spaced WAIT_CYCLES+2 cycles apart.
